// File: rtl/arith_macseq.sv
// -----------------------------------------------------------------------------
// arith_macseq
//
// Multiply-accumulate sequencer for the arith datapath. One command carries a
// chain length N and a signed/unsigned flag. The sequencer accepts N operand
// pairs and drives them into arith as one IMULTN (clears the accumulator)
// followed by N-1 IMACN beats. It then waits for the multiplier pipeline to
// drain, issues RESMAC to move the accumulator onto the result bus, captures
// the 32-bit sum and holds it until the consumer takes it. While busy it owns
// every arith control strobe.
//
// Ports
//   sys_clk, reset      clock, synchronous active-high reset
//   cmd_valid/ready     command handshake; cmd_count, cmd_signed qualify it
//   abort               drop the current chain (ignored when idle)
//   op_valid/ready      operand pair handshake; op_src, op_dst carry the pair
//   srcdp, dstdp        registered operands towards arith
//   macop               0 = IMULTN, 1 = IMACN
//   multsel, multsign   multiplier strobe and its signedness
//   ressel, resld       arith result mux select and result register load
//   flagld              flag load, issued together with RESMAC
//   result              arith result bus
//   res_valid/ready     result handshake; res_data carries the sum
//   busy                sequencer is not idle
// -----------------------------------------------------------------------------
module arith_macseq #(
   parameter int         COUNT_W    = 5,
   parameter int         PIPE_LAT   = 2,
   parameter logic [2:0] RESSEL_MUL = 3'd2,
   parameter logic [2:0] RESSEL_ACC = 3'd3
) (
   input  logic               sys_clk,
   input  logic               reset,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [COUNT_W-1:0] cmd_count,
   input  logic               cmd_signed,
   input  logic               abort,
   input  logic               op_valid,
   output logic               op_ready,
   input  logic [31:0]        op_src,
   input  logic [31:0]        op_dst,
   output logic [31:0]        srcdp,
   output logic [31:0]        dstdp,
   output logic               macop,
   output logic               multsel,
   output logic               multsign,
   output logic [2:0]         ressel,
   output logic               resld,
   output logic               flagld,
   input  logic [31:0]        result,
   output logic               res_valid,
   output logic [31:0]        res_data,
   input  logic               res_ready,
   output logic               busy
);

   localparam int WAIT_W = (PIPE_LAT < 2) ? 1 : $clog2(PIPE_LAT + 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_MUL    = 3'd1,
      S_WAIT   = 3'd2,
      S_RESMAC = 3'd3,
      S_CAPT   = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   state_t               state_q,     state_d;
   logic [COUNT_W-1:0]   count_q,     count_d;
   logic                 signed_q,    signed_d;
   logic [COUNT_W-1:0]   beat_q,      beat_d;
   logic [WAIT_W-1:0]    wait_q,      wait_d;
   logic [31:0]          srcdp_q,     srcdp_d;
   logic [31:0]          dstdp_q,     dstdp_d;
   logic                 macop_q,     macop_d;
   logic                 multsel_q,   multsel_d;
   logic                 multsign_q,  multsign_d;
   logic [2:0]           ressel_q,    ressel_d;
   logic                 resld_q,     resld_d;
   logic                 flagld_q,    flagld_d;
   logic                 res_valid_q, res_valid_d;
   logic [31:0]          res_data_q,  res_data_d;
   logic                 cmd_ready_q, cmd_ready_d;
   logic                 op_ready_q,  op_ready_d;
   logic                 busy_q,      busy_d;

   logic                 cmd_fire;
   logic                 op_fire;
   logic                 abort_hit;

   // ready flags are registered copies of the state, so the handshakes can
   // be qualified directly with them
   assign cmd_fire  = cmd_valid && cmd_ready_q;
   assign abort_hit = abort && (state_q != S_IDLE);
   // an abort in the same cycle drops the offered beat
   assign op_fire   = op_valid && op_ready_q && !abort;

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      signed_d   = signed_q;
      beat_d     = beat_q;
      wait_d     = wait_q;
      srcdp_d    = srcdp_q;
      dstdp_d    = dstdp_q;
      res_data_d = res_data_q;
      // strobes are single-cycle pulses; they default low every cycle
      macop_d    = 1'b0;
      multsel_d  = 1'b0;
      multsign_d = 1'b0;
      ressel_d   = 3'd0;
      resld_d    = 1'b0;
      flagld_d   = 1'b0;

      if (abort_hit) begin
         state_d = S_IDLE;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (cmd_fire) begin
                  count_d  = cmd_count;
                  signed_d = cmd_signed;
                  beat_d   = '0;
                  if (cmd_count == '0) begin
                     // empty chain: nothing touches arith, the sum is zero
                     res_data_d = '0;
                     state_d    = S_DONE;
                  end else begin
                     state_d = S_MUL;
                  end
               end
            end
            S_MUL: begin
               if (op_fire) begin
                  srcdp_d    = op_src;
                  dstdp_d    = op_dst;
                  multsel_d  = 1'b1;
                  resld_d    = 1'b1;
                  ressel_d   = RESSEL_MUL;
                  macop_d    = (beat_q != '0);
                  multsign_d = signed_q;
                  beat_d     = beat_q + 1'b1;
                  if (beat_q == count_q - 1'b1) begin
                     wait_d  = WAIT_W'(PIPE_LAT);
                     state_d = S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               // the first WAIT cycle is the one carrying the last multsel,
               // so leaving at count 1 puts RESMAC PIPE_LAT cycles after it
               if (wait_q <= WAIT_W'(1)) begin
                  state_d = S_RESMAC;
               end else begin
                  wait_d = wait_q - 1'b1;
               end
            end
            S_RESMAC: begin
               state_d = S_CAPT;
            end
            S_CAPT: begin
               // arith loaded the accumulator during RESMAC; it is on the
               // result bus now
               res_data_d = result;
               state_d    = S_DONE;
            end
            S_DONE: begin
               if (res_ready) state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end

      // RESMAC strobes are registered on entry so they line up with the state
      if (state_d == S_RESMAC && state_q != S_RESMAC) begin
         resld_d  = 1'b1;
         flagld_d = 1'b1;
         ressel_d = RESSEL_ACC;
      end

      res_valid_d = (state_d == S_DONE);
      cmd_ready_d = (state_d == S_IDLE);
      op_ready_d  = (state_d == S_MUL);
      busy_d      = (state_d != S_IDLE);
   end

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         count_q     <= '0;
         signed_q    <= 1'b0;
         beat_q      <= '0;
         wait_q      <= '0;
         srcdp_q     <= '0;
         dstdp_q     <= '0;
         macop_q     <= 1'b0;
         multsel_q   <= 1'b0;
         multsign_q  <= 1'b0;
         ressel_q    <= 3'd0;
         resld_q     <= 1'b0;
         flagld_q    <= 1'b0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         cmd_ready_q <= 1'b1;
         op_ready_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         signed_q    <= signed_d;
         beat_q      <= beat_d;
         wait_q      <= wait_d;
         srcdp_q     <= srcdp_d;
         dstdp_q     <= dstdp_d;
         macop_q     <= macop_d;
         multsel_q   <= multsel_d;
         multsign_q  <= multsign_d;
         ressel_q    <= ressel_d;
         resld_q     <= resld_d;
         flagld_q    <= flagld_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         cmd_ready_q <= cmd_ready_d;
         op_ready_q  <= op_ready_d;
         busy_q      <= busy_d;
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign op_ready  = op_ready_q;
   assign srcdp     = srcdp_q;
   assign dstdp     = dstdp_q;
   assign macop     = macop_q;
   assign multsel   = multsel_q;
   assign multsign  = multsign_q;
   assign ressel    = ressel_q;
   assign resld     = resld_q;
   assign flagld    = flagld_q;
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_arith_macseq.sv
module tb_arith_macseq;

   localparam int COUNT_W  = 5;
   localparam int PIPE_LAT = 2;

   logic               sys_clk = 1'b0;
   logic               reset;
   logic               cmd_valid;
   logic               cmd_ready;
   logic [COUNT_W-1:0] cmd_count;
   logic               cmd_signed;
   logic               abort;
   logic               op_valid;
   logic               op_ready;
   logic [31:0]        op_src;
   logic [31:0]        op_dst;
   logic [31:0]        srcdp;
   logic [31:0]        dstdp;
   logic               macop;
   logic               multsel;
   logic               multsign;
   logic [2:0]         ressel;
   logic               resld;
   logic               flagld;
   logic [31:0]        result;
   logic               res_valid;
   logic [31:0]        res_data;
   logic               res_ready;
   logic               busy;

   arith_macseq #(.COUNT_W(COUNT_W), .PIPE_LAT(PIPE_LAT)) dut (
      .sys_clk(sys_clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_count(cmd_count), .cmd_signed(cmd_signed),
      .abort(abort),
      .op_valid(op_valid), .op_ready(op_ready),
      .op_src(op_src), .op_dst(op_dst),
      .srcdp(srcdp), .dstdp(dstdp),
      .macop(macop), .multsel(multsel), .multsign(multsign),
      .ressel(ressel), .resld(resld), .flagld(flagld),
      .result(result),
      .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
      .busy(busy)
   );

   always #5 sys_clk = ~sys_clk;

   int total = 0;
   int bad   = 0;

   logic [31:0] exp_q[$];

   // behavioural arith: multiplier + accumulator + result register
   logic [31:0] acc_m = 32'd0;
   logic [31:0] res_m = 32'd0;
   logic [31:0] prod_m;
   always @(posedge sys_clk) begin
      prod_m = multsign ? 32'($signed(srcdp) * $signed(dstdp)) : 32'(srcdp * dstdp);
      if (multsel) acc_m <= macop ? acc_m + prod_m : prod_m;
      if (resld)   res_m <= (ressel == 3'd3) ? acc_m : prod_m;
   end
   assign result = res_m;

   // strobe monitor, sampled on the falling edge
   int   cyc = 0;
   int   mul_cnt, resld_cnt, resmac_cnt, mul_cyc, resmac_cyc, hold_bad;
   logic macop_log[$];
   logic sign_log[$];
   logic hold_en = 1'b0;
   logic [31:0] prev_src;
   always @(posedge sys_clk) cyc <= cyc + 1;
   always @(negedge sys_clk) begin
      if (!reset) begin
         if (multsel) begin
            mul_cnt++;
            macop_log.push_back(macop);
            sign_log.push_back(multsign);
            mul_cyc = cyc;
         end
         if (resld) resld_cnt++;
         if (resld && ressel == 3'd3) begin
            resmac_cnt++;
            resmac_cyc = cyc;
         end
         if (hold_en && !multsel && srcdp !== prev_src) hold_bad++;
      end
      prev_src = srcdp;
   end

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic clear_mon();
      mul_cnt = 0; resld_cnt = 0; resmac_cnt = 0;
      mul_cyc = 0; resmac_cyc = 0; hold_bad = 0;
      macop_log.delete();
      sign_log.delete();
   endtask

   task automatic send_cmd(input int n, input bit sg);
      int t = 0;
      while (!cmd_ready && t < 50) begin tick(); t++; end
      if (!cmd_ready) begin
         total++; bad++;
         $display("FAIL cmd_ready_timeout got=%0b want=1", cmd_ready);
      end
      cmd_valid  = 1'b1;
      cmd_count  = COUNT_W'(n);
      cmd_signed = sg;
      tick();
      cmd_valid  = 1'b0;
   endtask

   task automatic send_op(input logic [31:0] s, input logic [31:0] d, input int gap);
      int t = 0;
      repeat (gap) tick();
      op_valid = 1'b1;
      op_src   = s;
      op_dst   = d;
      while (!op_ready && t < 50) begin tick(); t++; end
      if (!op_ready) begin
         total++; bad++;
         $display("FAIL op_ready_timeout got=%0b want=1", op_ready);
      end
      tick();
      op_valid = 1'b0;
   endtask

   task automatic wait_res(output bit ok, output int waited);
      waited = 0;
      while (!res_valid && waited < 50) begin tick(); waited++; end
      ok = res_valid;
   endtask

   task automatic take_res();
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
   endtask

   task automatic check_sum(input string name);
      logic [31:0] e;
      total++;
      if (exp_q.size() == 0) begin
         bad++;
         $display("FAIL %s scoreboard_empty got=%h", name, res_data);
      end else begin
         e = exp_q.pop_front();
         if (res_data !== e) begin
            bad++;
            $display("FAIL %s sum got=%h want=%h", name, res_data, e);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      total++;
      if (cmd_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0 || op_ready !== 1'b0) begin
         bad++;
         $display("FAIL reset_ctrl got rdy=%b busy=%b vld=%b oprdy=%b want 1 0 0 0",
                  cmd_ready, busy, res_valid, op_ready);
      end
      total++;
      if (multsel !== 1'b0 || resld !== 1'b0 || flagld !== 1'b0 || srcdp !== 32'd0 || res_data !== 32'd0) begin
         bad++;
         $display("FAIL reset_data got ms=%b ld=%b fl=%b src=%h res=%h want all 0",
                  multsel, resld, flagld, srcdp, res_data);
      end
   endtask

   task automatic test_single();
      bit ok; int w;
      clear_mon();
      exp_q.push_back(32'd15);
      send_cmd(1, 1'b0);
      send_op(32'd3, 32'd5, 0);
      total++;
      if (multsel !== 1'b1 || resld !== 1'b1 || macop !== 1'b0 || ressel !== 3'd2 ||
          srcdp !== 32'd3 || dstdp !== 32'd5 || multsign !== 1'b0) begin
         bad++;
         $display("FAIL single_beat got ms=%b ld=%b mac=%b sel=%0d src=%0d dst=%0d sg=%b want 1 1 0 2 3 5 0",
                  multsel, resld, macop, ressel, srcdp, dstdp, multsign);
      end
      wait_res(ok, w);
      total++;
      if (!ok) begin bad++; $display("FAIL single_timeout got=0 want=1"); end
      check_sum("single");
      total++;
      if (mul_cnt !== 1 || resmac_cnt !== 1 || resmac_cyc - mul_cyc !== PIPE_LAT) begin
         bad++;
         $display("FAIL single_strobes got mul=%0d resmac=%0d lat=%0d want 1 1 %0d",
                  mul_cnt, resmac_cnt, resmac_cyc - mul_cyc, PIPE_LAT);
      end
      repeat (3) tick();
      total++;
      if (res_valid !== 1'b1 || res_data !== 32'd15 || cmd_ready !== 1'b0) begin
         bad++;
         $display("FAIL single_hold got vld=%b res=%0d rdy=%b want 1 15 0", res_valid, res_data, cmd_ready);
      end
      take_res();
      total++;
      if (res_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL single_release got vld=%b rdy=%b busy=%b want 0 1 0", res_valid, cmd_ready, busy);
      end
   endtask

   task automatic test_signed();
      bit ok; int w;
      clear_mon();
      exp_q.push_back(32'd19);
      send_cmd(3, 1'b1);
      send_op(32'd2, 32'd3, 0);
      send_op(32'd4, 32'd5, 0);
      send_op(32'hFFFF_FFFF, 32'd7, 2);
      wait_res(ok, w);
      total++;
      if (!ok) begin bad++; $display("FAIL signed_timeout got=0 want=1"); end
      check_sum("signed");
      total++;
      if (mul_cnt !== 3 || macop_log.size() != 3 ||
          macop_log[0] !== 1'b0 || macop_log[1] !== 1'b1 || macop_log[2] !== 1'b1) begin
         bad++;
         $display("FAIL signed_macop got n=%0d want 3 beats with macop 0,1,1", mul_cnt);
      end
      total++;
      if (sign_log.size() != 3 || sign_log[0] !== 1'b1 || sign_log[1] !== 1'b1 || sign_log[2] !== 1'b1) begin
         bad++;
         $display("FAIL signed_multsign got n=%0d want 3 beats with multsign 1", sign_log.size());
      end
      take_res();
   endtask

   task automatic test_gaps();
      bit ok; int w;
      clear_mon();
      exp_q.push_back(32'hFFF8_0004);
      send_cmd(4, 1'b0);
      hold_en = 1'b1;
      for (int i = 0; i < 4; i++) send_op(32'h0000_FFFF + 32'(i) * 32'h1_0000 * 0, 32'h0000_FFFF, i);
      wait_res(ok, w);
      hold_en = 1'b0;
      total++;
      if (!ok) begin bad++; $display("FAIL gaps_timeout got=0 want=1"); end
      check_sum("gaps");
      total++;
      if (mul_cnt !== 4 || resmac_cnt !== 1) begin
         bad++;
         $display("FAIL gaps_pulses got mul=%0d resmac=%0d want 4 1", mul_cnt, resmac_cnt);
      end
      total++;
      if (hold_bad !== 0) begin
         bad++;
         $display("FAIL gaps_hold got changes=%0d want 0", hold_bad);
      end
      take_res();
   endtask

   task automatic test_zero();
      bit ok; int w;
      clear_mon();
      exp_q.push_back(32'd0);
      send_cmd(0, 1'b0);
      wait_res(ok, w);
      total++;
      if (!ok || w > 1) begin
         bad++;
         $display("FAIL zero_latency got vld=%b extra_wait=%0d want 1 <=1", ok, w);
      end
      check_sum("zero");
      total++;
      if (mul_cnt !== 0 || resld_cnt !== 0) begin
         bad++;
         $display("FAIL zero_strobes got mul=%0d ld=%0d want 0 0", mul_cnt, resld_cnt);
      end
      take_res();
   endtask

   task automatic test_abort();
      bit ok; int w;
      clear_mon();
      send_cmd(5, 1'b1);
      send_op(32'd1, 32'd1, 0);
      send_op(32'd2, 32'd2, 0);
      op_valid = 1'b1; op_src = 32'd9; op_dst = 32'd9; abort = 1'b1;
      tick();
      op_valid = 1'b0; abort = 1'b0;
      total++;
      if (busy !== 1'b0 || cmd_ready !== 1'b1 || op_ready !== 1'b0 || multsel !== 1'b0 || srcdp !== 32'd2) begin
         bad++;
         $display("FAIL abort_mul got busy=%b rdy=%b oprdy=%b ms=%b src=%0d want 0 1 0 0 2",
                  busy, cmd_ready, op_ready, multsel, srcdp);
      end
      repeat (6) tick();
      total++;
      if (mul_cnt !== 2 || resmac_cnt !== 0 || res_valid !== 1'b0) begin
         bad++;
         $display("FAIL abort_mul_after got mul=%0d resmac=%0d vld=%b want 2 0 0", mul_cnt, resmac_cnt, res_valid);
      end

      clear_mon();
      send_cmd(2, 1'b0);
      send_op(32'd1, 32'd1, 0);
      send_op(32'd2, 32'd2, 0);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      total++;
      if (busy !== 1'b0 || cmd_ready !== 1'b1) begin
         bad++;
         $display("FAIL abort_wait got busy=%b rdy=%b want 0 1", busy, cmd_ready);
      end
      repeat (6) tick();
      total++;
      if (resmac_cnt !== 0 || flagld !== 1'b0 || res_valid !== 1'b0) begin
         bad++;
         $display("FAIL abort_wait_after got resmac=%0d fl=%b vld=%b want 0 0 0", resmac_cnt, flagld, res_valid);
      end

      abort = 1'b1;
      tick();
      abort = 1'b0;
      exp_q.push_back(32'd14);
      send_cmd(2, 1'b0);
      send_op(32'd1, 32'd2, 0);
      send_op(32'd3, 32'd4, 1);
      wait_res(ok, w);
      total++;
      if (!ok) begin bad++; $display("FAIL recover_timeout got=0 want=1"); end
      check_sum("recover");
      take_res();
   endtask

   task automatic test_reset_done();
      bit ok; int w;
      send_cmd(1, 1'b0);
      send_op(32'd6, 32'd7, 0);
      wait_res(ok, w);
      total++;
      if (!ok || res_data !== 32'd42) begin
         bad++;
         $display("FAIL rstdone_pre got vld=%b res=%0d want 1 42", ok, res_data);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      total++;
      if (res_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 || srcdp !== 32'd0 || res_data !== 32'd0) begin
         bad++;
         $display("FAIL rstdone got vld=%b rdy=%b busy=%b src=%h res=%h want 0 1 0 0 0",
                  res_valid, cmd_ready, busy, srcdp, res_data);
      end
   endtask

   initial begin
      reset = 1'b1; cmd_valid = 1'b0; cmd_count = '0; cmd_signed = 1'b0;
      abort = 1'b0; op_valid = 1'b0; op_src = '0; op_dst = '0; res_ready = 1'b0;
      test_reset();
      test_single();
      test_signed();
      test_gaps();
      test_zero();
      test_abort();
      test_reset_done();
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
